// File: rtl/uart_pkg.sv
// uart_pkg: shared bridge constants and FIFO sizing defaults for the UART receive path
package uart_pkg;
  localparam logic [7:0] CMD_USB_UART = 8'hfc;
  localparam logic [7:0] CMD_ESP_UART = 8'hfb;
  localparam int RX_AW = 8;
  localparam int RX_THRESH = 16;
  localparam logic [15:0] RX_TIMEOUT = 16'd3500;
  function automatic int lvl_w(input int aw);
    return aw + 1;
  endfunction
endpackage

// File: rtl/uart_rx_fifo_mem.sv
// uart_rx_fifo_mem: 2^AW x 8 RAM, synchronous write and asynchronous read for first-word-fall-through
module uart_rx_fifo_mem #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem_q [2**AW];
  // write port; contents are never cleared
  always_ff @(posedge clk) if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: turns bridge rx_idx changes into FWFT FIFO pushes and raises a threshold/idle interrupt
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int          AW      = RX_AW,
  parameter int          THRESH  = RX_THRESH,
  parameter logic [15:0] TIMEOUT = RX_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             rx_data,
  input  logic [7:0]             rx_idx,
  input  logic                   link_busy,
  input  logic                   rd,
  input  logic                   clr,
  output logic [7:0]             dout,
  output logic                   empty,
  output logic                   full,
  output logic [lvl_w(AW)-1:0]   level,
  output logic                   overflow,
  output logic                   irq
);
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] THR = (AW+1)'(THRESH);
  logic [7:0] prev_idx_q;
  logic armed_q, rd_q, overflow_q, overflow_d, irq_q, irq_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] level_q, level_d;
  logic [15:0] idle_q, idle_d;
  logic push, pop, wr_en, rd_en;
  logic [7:0] rdata;
  uart_rx_fifo_mem #(.AW(AW)) u_mem (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wr_ptr_q),
    .wdata(rx_data),
    .raddr(rd_ptr_q),
    .rdata(rdata)
  );
  assign empty = level_q == '0;
  assign full = level_q == DEPTH;
  assign level = level_q;
  assign overflow = overflow_q;
  assign irq = irq_q;
  assign dout = empty ? 8'h00 : rdata;
  // push/pop qualification, pointer and level bookkeeping, idle timer and irq condition
  always_comb begin
    push = armed_q & ~link_busy & (rx_idx != prev_idx_q);
    pop = rd & ~rd_q & ~empty;
    wr_en = push & (~full | pop) & ~clr;
    rd_en = pop & ~clr;
    wr_ptr_d = clr ? '0 : wr_ptr_q + AW'(wr_en);
    rd_ptr_d = clr ? '0 : rd_ptr_q + AW'(rd_en);
    level_d = clr ? '0 : level_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    overflow_d = ~clr & (overflow_q | (push & full & ~pop));
    idle_d = (clr | push | pop | empty) ? 16'd0 : (idle_q == TIMEOUT) ? idle_q : idle_q + 16'd1;
    irq_d = (level_q >= THR) | ((TIMEOUT != 16'd0) & ~empty & (idle_q == TIMEOUT));
  end
  // state registers; prev_idx tracks rx_idx even in reset so the first sample never pushes
  always_ff @(posedge clk) begin
    prev_idx_q <= rx_idx;
    if (reset) begin
      armed_q <= 1'b0;
      rd_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
      overflow_q <= 1'b0;
      idle_q <= 16'd0;
      irq_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      rd_q <= rd;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q <= level_d;
      overflow_q <= overflow_d;
      idle_q <= idle_d;
      irq_q <= irq_d;
    end
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Downstream consumer of the MCU SPI bridge's UART receive outputs: rx_data plus a per-byte rx_idx that changes with each byte.
- Turns every rx_idx change into one push into a first-word-fall-through FIFO.
- Presents the head byte, level and status to the Z80-side zifi/evo RS232 port decoders.
- Raises an interrupt on a fill threshold or on an idle timeout.
- One instance each for the USB UART and the ESP UART.

Parameters:
- AW, 8, FIFO address width; depth = 2^AW bytes.
- THRESH, 16, irq asserts when level >= THRESH; valid range 1..2^AW.
- TIMEOUT, 16'd3500, idle clk cycles with data pending before irq asserts; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- rx_data  in  8  received byte from the bridge, valid when rx_idx changes
- rx_idx  in  8  byte sequence index from the bridge; any change = one new byte
- link_busy  in  1  bridge init in progress; rx_idx changes are not pushed while high
- rd  in  1  CPU read strobe, level; the FIFO pops on its rising edge
- clr  in  1  flush request, level; acts every cycle it is high
- dout  out  8  head byte (FWFT), 8'h00 when empty
- empty  out  1  FIFO empty
- full  out  1  FIFO full
- level  out  AW+1  bytes stored, 0..2^AW
- overflow  out  1  sticky: a byte was dropped
- irq  out  1  receive interrupt request

Behaviour:
- Synchronous active-high reset; clk is the only clock.
- Reset values: wr_ptr=0, rd_ptr=0, level=0, empty=1, full=0, overflow=0, irq=0, dout=0, armed=0, rd_q=0, idle counter=0.
- Change detect:
  - prev_idx <= rx_idx every cycle.
  - armed <= 1 one cycle after reset deassertion.
  - push = armed & ~link_busy & (rx_idx != prev_idx).
  - The first post-reset sample only loads prev_idx and never pushes.
  - An rx_idx change while link_busy is high is absorbed (prev_idx still updates) and never pushed later.
- Pop: pop = rd & ~rd_q & ~empty. rd_q <= rd. A rising edge of rd while empty is ignored and is not remembered.
- Latency: rx_idx changes in cycle n; mem[wr_ptr] is written at the end of n; empty, level and dout reflect the byte in cycle n+1.
- Pop at the end of cycle n: dout shows the next byte, or 0 if the FIFO is now empty, in cycle n+1.
- Pointers are AW bits and wrap naturally modulo 2^AW. level is AW+1 bits and is tracked explicitly; it is not derived from the pointers.
- empty = (level==0); full = (level==2^AW); both decoded from registered level.
- Push when full with no pop in the same cycle: the byte is dropped, pointers and level are unchanged, overflow <= 1.
- Push when full with a pop in the same cycle: accepted, level stays 2^AW, overflow unchanged.
- Push and pop in the same cycle when not empty and not full: both execute, level unchanged.
- clr has top priority:
  - wr_ptr, rd_ptr, level <= 0; overflow <= 0; idle counter <= 0.
  - A push or pop in the same cycle is discarded.
  - prev_idx still updates, so a byte arriving during clr is lost by design.
- Idle counter (16 bit):
  - Cleared on push, pop, clr, or when empty.
  - Otherwise increments, saturating at TIMEOUT.
- irq is registered: irq <= (level >= THRESH) | (TIMEOUT != 0 & ~empty & idle == TIMEOUT).
  - It deasserts the cycle after the condition clears, for example after the pop that empties the FIFO.
- Memory contents are not cleared on reset or clr; dout is gated to 0 when empty.

Decomposition:
- Shared package uart_pkg:
  - bridge command constants CMD_USB_UART=8'hfc, CMD_ESP_UART=8'hfb;
  - default FIFO width localparams;
  - level type width helper.
- Sub-module uart_rx_fifo_mem:
  - 2^AW x 8 dual-port RAM, synchronous write, asynchronous read, for FWFT.
  - Infers MLAB/LUT RAM.
- Change detect, pointers, level, overflow and irq logic stay in uart_rx_fifo.

Test Plan:
- Reset, then hold rx_idx=8'h37 constant, then set rx_idx=8'h38 with rx_data=8'h41 → no push from the initial value; cycle after the change: empty=0, level=1, dout=8'h41.
- Push 3 bytes 8'h10/8'h11/8'h12, then hold rd high 5 cycles → exactly one pop; dout=8'h11, level=2. Pulse rd twice more → dout=8'h00, empty=1. One further rd pulse leaves level=0.
- AW=4: push 17 bytes 0..16 → full=1 after the 16th, 17th dropped, overflow=1, dout=0. Pop all 16 → values 0..15 in order. clr → overflow=0.
- AW=4, full: push and rd rising edge in the same cycle → level stays 16, overflow stays 0. Remaining read-out continues the sequence ending with the new byte; wrap of pointers through 15→0 exercised.
- THRESH=4, TIMEOUT=10: push 1 byte → irq=0 for 10 cycles then irq=1; pop → irq=0 next cycle. Push 4 bytes back-to-back → irq=1 the cycle after level reaches 4.
- link_busy=1 while rx_idx steps 3 times → level stays 0. Drop link_busy, step once → level=1. clr asserted in the same cycle as a push → level=0 and the byte is lost.
